// File: rtl/jtframe_lfbuf_mover_pkg.sv
// jtframe_lfbuf_mover_pkg: state encoding and {frame_bit, v, col} address packing shared by mover, front end and bench
package jtframe_lfbuf_mover_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_REQ, RD_REQ, RD_WR} state_t;
  function automatic logic [31:0] pack_addr(input logic fb, input logic [15:0] v, input logic [15:0] col,
                                            input int vw, input int hw);
    return (32'(fb) << (vw + hw)) | (32'(v) << hw) | 32'(col);
  endfunction
endpackage

// File: rtl/jtframe_lfbuf_mover.sv
// jtframe_lfbuf_mover: drains completed object lines to 16-bit memory and fetches display lines during hblank
module jtframe_lfbuf_mover
  import jtframe_lfbuf_mover_pkg::*;
#(
  parameter int VW   = 8,
  parameter int HW   = 9,
  parameter int HMAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lhbl,
  input  logic [VW-1:0]    vrender,
  input  logic             frame,
  input  logic             ln_hs,
  input  logic [VW-1:0]    ln_v,
  output logic             line,
  output logic [HW-1:0]    fb_addr,
  input  logic [15:0]      fb_din,
  output logic             fb_clr,
  output logic             fb_done,
  output logic [HW-1:0]    rd_addr,
  output logic [15:0]      fb_dout,
  output logic             scr_we,
  output logic [VW+HW:0]   mem_addr,
  output logic [15:0]      mem_din,
  input  logic [15:0]      mem_dout,
  output logic             mem_we,
  output logic             mem_rd,
  input  logic             mem_ack,
  output logic             busy
);
  localparam int AW = VW + HW + 1;

  state_t          st_q;
  logic [HW-1:0]   col_q, fb_addr_q, rd_addr_q;
  logic [AW-1:0]   mem_addr_q;
  logic [15:0]     mem_din_q, fb_dout_q;
  logic            lhbl_q, line_q, wr_pend_q, rd_pend_q, wr_fb_q, rd_fb_q;
  logic            fb_clr_q, fb_done_q, scr_we_q, mem_we_q, mem_rd_q;
  logic [VW-1:0]   wr_v_q, rd_v_q, wr_v_d, rd_v_d;
  logic            wr_fb_d, rd_fb_d, rd_fall, wr_go, rd_go, last;

  function automatic logic [AW-1:0] addr(input logic fb, input logic [VW-1:0] v, input logic [HW-1:0] c);
    return AW'(pack_addr(fb, 16'(v), 16'(c), VW, HW));
  endfunction

  assign rd_fall = lhbl_q & ~lhbl;
  assign wr_v_d  = ln_hs ? ln_v : wr_v_q;
  assign wr_fb_d = ln_hs ? frame : wr_fb_q;
  assign rd_v_d  = rd_fall ? vrender + VW'(1) : rd_v_q;
  assign rd_fb_d = rd_fall ? ~frame : rd_fb_q;
  assign wr_go   = wr_pend_q | ln_hs;
  assign rd_go   = rd_pend_q | rd_fall;
  assign last    = col_q == HW'(HMAX);

  assign line     = line_q;
  assign fb_addr  = fb_addr_q;
  assign fb_clr   = fb_clr_q;
  assign fb_done  = fb_done_q;
  assign rd_addr  = rd_addr_q;
  assign fb_dout  = fb_dout_q;
  assign scr_we   = scr_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign mem_rd   = mem_rd_q;
  assign busy     = st_q != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      col_q      <= '0;
      fb_addr_q  <= '0;
      rd_addr_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      fb_dout_q  <= '0;
      wr_v_q     <= '0;
      rd_v_q     <= '0;
      lhbl_q     <= 1'b0;
      line_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_fb_q    <= 1'b0;
      rd_fb_q    <= 1'b0;
      fb_clr_q   <= 1'b0;
      fb_done_q  <= 1'b0;
      scr_we_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      lhbl_q    <= lhbl;
      wr_v_q    <= wr_v_d;
      wr_fb_q   <= wr_fb_d;
      rd_v_q    <= rd_v_d;
      rd_fb_q   <= rd_fb_d;
      line_q    <= line_q ^ ln_hs;
      wr_pend_q <= wr_pend_q | ln_hs;
      rd_pend_q <= rd_pend_q | rd_fall;
      fb_clr_q  <= 1'b0;
      fb_done_q <= 1'b0;
      scr_we_q  <= 1'b0;
      case (st_q)
        IDLE: begin
          if (rd_go) begin
            st_q       <= RD_REQ;
            col_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr(rd_fb_d, rd_v_d, '0);
          end else if (wr_go) begin
            st_q      <= WR_ADDR;
            col_q     <= '0;
            fb_addr_q <= '0;
          end
        end
        // a pending clear keeps the old address for one cycle before presenting the next column
        WR_ADDR: begin
          if (fb_clr_q) fb_addr_q <= col_q;
          else begin
            st_q       <= WR_REQ;
            mem_we_q   <= 1'b1;
            mem_din_q  <= fb_din;
            mem_addr_q <= addr(wr_fb_q, wr_v_q, col_q);
          end
        end
        WR_REQ: begin
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            fb_clr_q <= 1'b1;
            col_q    <= col_q + HW'(1);
            st_q     <= last ? IDLE : WR_ADDR;
            if (last) begin
              fb_done_q <= 1'b1;
              wr_pend_q <= ln_hs;
            end
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            mem_rd_q  <= 1'b0;
            fb_dout_q <= mem_dout;
            rd_addr_q <= col_q;
            scr_we_q  <= 1'b1;
            st_q      <= RD_WR;
          end
        end
        RD_WR: begin
          col_q <= col_q + HW'(1);
          if (last) begin
            st_q      <= IDLE;
            rd_pend_q <= rd_fall;
          end else begin
            st_q       <= RD_REQ;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr(rd_fb_q, rd_v_q, col_q + HW'(1));
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/jtframe_lfbuf_mover.md
# jtframe_lfbuf_mover

Memory-side engine of the line-based frame buffer. It drains each completed object line from the input line buffer into external 16-bit memory, clearing each word after storage. During horizontal blank it also fetches the next display line from the previously completed frame into the screen line buffer. It sits between the line-buffer front end and a word-wide SDRAM request/acknowledge port. It generates every control signal that front end consumes: `line`, `fb_addr`, `fb_clr`, `fb_done`, `rd_addr`, `fb_dout`, `scr_we`.

## Interface
- `VW`, 8, vertical line-number width
- `HW`, 9, column address width
- `HMAX`, 255, last column transferred per line (columns 0..HMAX)
- `clk` in 1: single clock for all logic
- `rst` in 1: synchronous, active-high reset
- `lhbl` in 1: horizontal blank, active low; its falling edge requests a read pass
- `vrender` in VW: line about to be displayed; the pass fetches `vrender+1`
- `frame` in 1: frame currently being written; reads use `~frame`
- `ln_hs` in 1: one-cycle pulse meaning line `ln_v` is complete; requests a write pass
- `ln_v` in VW: line number of the completed line
- `line` out 1: input line-buffer half being drained; toggles on each accepted `ln_hs`
- `fb_addr` out HW: column being read from the input line buffer
- `fb_din` in 16: line-buffer data; valid 1 cycle after `fb_addr`
- `fb_clr` out 1: one-cycle pulse that clears word `fb_addr`
- `fb_done` out 1: one-cycle pulse at the end of a write pass
- `rd_addr` out HW: screen line-buffer write column
- `fb_dout` out 16: screen line-buffer write data
- `scr_we` out 1: screen line-buffer write strobe
- `mem_addr` out VW+HW+1: external word address `{frame_bit, v, col}`
- `mem_din` out 16: external write data
- `mem_dout` in 16: external read data
- `mem_we` out 1: write request
- `mem_rd` out 1: read request
- `mem_ack` in 1: one-cycle pulse meaning the current request completed
- `busy` out 1: high whenever the state is not IDLE

## Operation
- Pending flags:
  - `wr_pend` is set by `ln_hs`, which also latches `ln_v` and toggles `line`.
  - `rd_pend` is set by a `lhbl` falling edge, which latches `vrender+1` (wraps modulo 2^VW) and `~frame`.
- States: IDLE, WR_ADDR, WR_REQ, RD_REQ, RD_WR.
- In IDLE, `rd_pend` has priority over `wr_pend`. A pass is atomic: it runs all columns 0..HMAX before the state returns to IDLE.
- Write pass:
  - WR_ADDR drives `fb_addr=col`, then moves to WR_REQ.
  - WR_REQ registers `mem_din=fb_din` and asserts `mem_we` with `mem_addr={frame_l, v_wr, col}` until `mem_ack`.
  - On the ack cycle: `fb_clr=1` with `fb_addr` unchanged, `mem_we` drops, and `col` increments.
  - After column HMAX: `fb_done` pulses, `wr_pend` clears, and the state returns to IDLE.
- Read pass:
  - RD_REQ asserts `mem_rd` with `{~frame_l, v_rd, col}` until `mem_ack`.
  - On ack, `fb_dout<=mem_dout` and `rd_addr<=col`.
  - RD_WR then pulses `scr_we` for one cycle and increments `col`.
  - After column HMAX: `rd_pend` clears and the state returns to IDLE.
- Retriggers and simultaneous events:
  - `ln_hs` or a `lhbl` fall while the same flag is already pending re-latches the parameters and keeps the single pending flag. There is no queueing.
  - `ln_hs` and a `lhbl` fall in the same cycle set both flags; the read pass runs first.
- `mem_we` and `mem_rd` are never high together. Once asserted, a request holds its address and data stable until `mem_ack`.

## Timing
- Reset: state IDLE, `col=0`, both pending flags 0. All outputs are 0, including `line`, `busy` and every strobe.
- Reset mid-pass drops `mem_we`/`mem_rd` on the next edge, without waiting for `mem_ack`.
- Latencies:
  - `ln_hs` to first `mem_we`: 2 cycles from IDLE.
  - `lhbl` fall to first `mem_rd`: 1 cycle from IDLE (edge detect plus state).
  - Per word: write takes 1 + (cycles to ack) + 1; read takes (cycles to ack) + 1.
- `mem_ack` outside a request is ignored.
- Column arithmetic is HW-bit; `col` resets to 0 at the start of each pass.

## Structure
- Shared package holds the state encoding and the address-packing function `{frame_bit, v, col}`, so the front end and test bench reuse them.
- No sub-module is needed. A single `jtframe_lfbuf_mover` of roughly 200 lines is the expected size; the edge detectors stay inline.

## Test plan
- Reset, then `ln_hs` with `ln_v=5`, `frame=1`, zero-wait ack → HMAX+1 writes at `{1,5,0}`..`{1,5,255}`, one `fb_clr` per word, `fb_done` once, `line=1`.
- `lhbl` fall with `vrender=9`, `frame=1`, memory returning data equal to the address → 256 `scr_we` pulses, `rd_addr` 0..255, reads from `{0,10,col}`.
- `ln_hs` and `lhbl` fall in the same cycle → read pass completes fully before the first `mem_we`; `mem_we` and `mem_rd` are never both high.
- Random 0–7 cycle ack delays → `mem_addr`/`mem_din` stay stable while a request is held; counts match the zero-wait case.
- `vrender=255`, VW=8 → reads target line 0.
- Assert `rst` during word 100 of a write pass → next cycle all outputs 0 and state IDLE; a later `ln_hs` restarts the pass at column 0.
